// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce dispatcher and the SHA-256 hash-core array.
// The optional per-batch watchdog is enabled in nonce_dispatcher by NONCE_DISPATCH_WATCHDOG_EN.
package bitcoin_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [255:0] digest_t;
    typedef logic [95:0]  hdr_tail_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        CHECK  = 3'd4,
        FINISH = 3'd5
    } disp_state_t;

    // SHA-256 initial hash value, word0 in the most significant position
    localparam digest_t SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic int lane_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nonce_hit_select.sv
// Combinational winner selection: lowest-index active lane whose digest is <= target,
// plus the number of active lanes in the batch.
module nonce_hit_select
    import bitcoin_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int LANE_W    = lane_width(NUM_CORES)
) (
    input  logic [NUM_CORES*256-1:0] digests,
    input  logic [NUM_CORES-1:0]     active_mask,
    input  digest_t                  target,
    output logic                     hit,
    output logic [LANE_W-1:0]        hit_lane,
    output digest_t                  hit_digest,
    output word_t                    lane_count
);

    logic [NUM_CORES-1:0] lane_hit;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_cmp
            assign lane_hit[gi] = active_mask[gi] && (digests[256*gi +: 256] <= target);
        end
    endgenerate

    // Walk from the top down so the lowest hitting lane is the one left standing
    always_comb begin
        hit        = 1'b0;
        hit_lane   = '0;
        hit_digest = '0;
        lane_count = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (lane_hit[i]) begin
                hit        = 1'b1;
                hit_lane   = LANE_W'(i);
                hit_digest = digests[256*i +: 256];
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            lane_count = lane_count + word_t'(active_mask[i]);
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// Feeds batches of nonces to NUM_CORES SHA-256 cores and reports the lowest winning nonce.
// Define NONCE_DISPATCH_WATCHDOG_EN to abort a batch that stalls for TIMEOUT_CYCLES in WAIT.
module nonce_dispatcher
    import bitcoin_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [255:0]             midstate,
    input  logic [95:0]              hdr_tail,
    input  logic [31:0]              nonce_base,
    input  logic [31:0]              nonce_count,
    input  logic [255:0]             target,
    output logic [NUM_CORES-1:0]     core_rst_n,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [255:0]             core_inh,
    output logic [NUM_CORES*128-1:0] core_message,
    input  logic [NUM_CORES*256-1:0] core_outs,
    input  logic [NUM_CORES-1:0]     core_done,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic [31:0]              found_nonce,
    output logic [255:0]             found_digest,
    output logic [31:0]              hashes_done,
    output logic                     error
);

    localparam int LANE_W = lane_width(NUM_CORES);

    disp_state_t state_reg, state_next;

    digest_t                  midstate_reg;
    hdr_tail_t                hdr_tail_reg;
    digest_t                  target_reg;
    word_t                    next_nonce_reg;
    word_t                    remaining_reg;
    logic [NUM_CORES-1:0]     active_mask_reg;
    logic [NUM_CORES*128-1:0] message_reg;
    logic                     found_reg;
    word_t                    found_nonce_reg;
    digest_t                  found_digest_reg;
    word_t                    hashes_done_reg;

    logic                     hit;
    logic [LANE_W-1:0]        hit_lane;
    digest_t                  hit_digest;
    word_t                    lane_count;
    logic                     all_done;
    logic                     wdt_expired;

    word_t                    batch_nonce;
    word_t                    batch_remaining;
    hdr_tail_t                batch_tail;
    logic [NUM_CORES-1:0]     mask_next;
    logic [NUM_CORES*128-1:0] msg_next;

    nonce_hit_select #(
        .NUM_CORES (NUM_CORES),
        .LANE_W    (LANE_W)
    ) u_hit_select (
        .digests     (core_outs),
        .active_mask (active_mask_reg),
        .target      (target_reg),
        .hit         (hit),
        .hit_lane    (hit_lane),
        .hit_digest  (hit_digest),
        .lane_count  (lane_count)
    );

    assign all_done = ((core_done & active_mask_reg) == active_mask_reg);

    // Batch parameters for the next CLEAR: straight from the inputs on a fresh start,
    // otherwise advanced past the batch that is being checked.
    always_comb begin
        batch_nonce     = next_nonce_reg + word_t'(NUM_CORES);
        batch_remaining = remaining_reg - lane_count;
        batch_tail      = hdr_tail_reg;
        if (state_reg == IDLE) begin
            batch_nonce     = nonce_base;
            batch_remaining = nonce_count;
            batch_tail      = hdr_tail;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
            assign mask_next[gi]               = (word_t'(gi) < batch_remaining);
            assign msg_next[128*gi +: 128]     = {batch_tail, batch_nonce + word_t'(gi)};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (nonce_count == '0) ? FINISH : CLEAR;
                end
            end
            CLEAR:  state_next = LAUNCH;
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (all_done) begin
                    state_next = CHECK;
                end else if (wdt_expired) begin
                    state_next = FINISH;
                end
            end
            CHECK: begin
                if (hit || (remaining_reg == lane_count)) begin
                    state_next = FINISH;
                end else begin
                    state_next = CLEAR;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        core_rst_n = '0;
        core_start = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            CLEAR: busy = 1'b1;
            LAUNCH: begin
                busy       = 1'b1;
                core_rst_n = '1;
                core_start = active_mask_reg;
            end
            WAIT, CHECK: begin
                busy       = 1'b1;
                core_rst_n = '1;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            midstate_reg     <= '0;
            hdr_tail_reg     <= '0;
            target_reg       <= '0;
            next_nonce_reg   <= '0;
            remaining_reg    <= '0;
            active_mask_reg  <= '0;
            message_reg      <= '0;
            found_reg        <= 1'b0;
            found_nonce_reg  <= '0;
            found_digest_reg <= '0;
            hashes_done_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        midstate_reg    <= midstate;
                        hdr_tail_reg    <= hdr_tail;
                        target_reg      <= target;
                        next_nonce_reg  <= nonce_base;
                        remaining_reg   <= nonce_count;
                        found_reg       <= 1'b0;
                        hashes_done_reg <= '0;
                    end
                end
                CHECK: begin
                    hashes_done_reg <= hashes_done_reg + lane_count;
                    next_nonce_reg  <= batch_nonce;
                    remaining_reg   <= batch_remaining;
                    if (hit) begin
                        found_reg        <= 1'b1;
                        found_nonce_reg  <= next_nonce_reg + word_t'(hit_lane);
                        found_digest_reg <= hit_digest;
                    end
                end
                default: ;
            endcase
            if (state_next == CLEAR) begin
                active_mask_reg <= mask_next;
                message_reg     <= msg_next;
            end
        end
    end

`ifdef NONCE_DISPATCH_WATCHDOG_EN
    logic [15:0] wdt_reg;
    logic        error_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_reg   <= '0;
            error_reg <= 1'b0;
        end else begin
            if (state_reg == LAUNCH) begin
                wdt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wdt_reg <= wdt_reg + 16'd1;
            end
            if (state_reg == IDLE && start) begin
                error_reg <= 1'b0;
            end else if (state_reg == WAIT && !all_done && wdt_expired) begin
                error_reg <= 1'b1;
            end
        end
    end

    // Fires on the last WAIT cycle so the batch occupies exactly TIMEOUT_CYCLES cycles
    assign wdt_expired = (wdt_reg == 16'(TIMEOUT_CYCLES - 1));
    assign error       = error_reg;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wdt_expired = 1'b0;
    assign error       = 1'b0;
`endif

    assign core_inh     = midstate_reg;
    assign core_message = message_reg;
    assign found        = found_reg;
    assign found_nonce  = found_nonce_reg;
    assign found_digest = found_digest_reg;
    assign hashes_done  = hashes_done_reg;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher with a behavioural four-lane hash-core model.
// Compile with NONCE_DISPATCH_WATCHDOG_EN to also exercise the watchdog.
module tb_nonce_dispatcher;
    import bitcoin_pkg::*;

    localparam int NC  = 4;
    localparam int TMO = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              start;
    logic [255:0]      midstate;
    logic [95:0]       hdr_tail;
    logic [31:0]       nonce_base;
    logic [31:0]       nonce_count;
    logic [255:0]      target;
    logic [NC-1:0]     core_rst_n;
    logic [NC-1:0]     core_start;
    logic [255:0]      core_inh;
    logic [NC*128-1:0] core_message;
    logic [NC*256-1:0] core_outs;
    logic [NC-1:0]     core_done;
    logic              busy;
    logic              done;
    logic              found;
    logic [31:0]       found_nonce;
    logic [255:0]      found_digest;
    logic [31:0]       hashes_done;
    logic              error;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0]       hit_a = '0;
    logic [31:0]       hit_b = '0;
    logic              hit_a_en = 1'b0;
    logic              hit_b_en = 1'b0;
    logic [NC-1:0]     stuck_mask = '0;
    logic [NC-1:0]     start_log[$];
    logic [NC*128-1:0] msg_log[$];

    localparam logic [255:0] TGT_HI0 = {32'h0, {224{1'b1}}};
    localparam logic [95:0]  TAIL    = 96'h1111_2222_3333_4444_5555_6666;

    nonce_dispatcher #(
        .NUM_CORES      (NC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .midstate     (midstate),
        .hdr_tail     (hdr_tail),
        .nonce_base   (nonce_base),
        .nonce_count  (nonce_count),
        .target       (target),
        .core_rst_n   (core_rst_n),
        .core_start   (core_start),
        .core_inh     (core_inh),
        .core_message (core_message),
        .core_outs    (core_outs),
        .core_done    (core_done),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .found_nonce  (found_nonce),
        .found_digest (found_digest),
        .hashes_done  (hashes_done),
        .error        (error)
    );

    // Hit nonces get a digest with a zero top word, all others a top word of all ones
    function automatic logic [255:0] model_digest(input logic [31:0] n);
        if ((hit_a_en && n == hit_a) || (hit_b_en && n == hit_b))
            return {32'h0, 192'h0, n};
        return {32'hFFFF_FFFF, 192'h0, n};
    endfunction

    for (genvar gi = 0; gi < NC; gi++) begin : g_core
        logic         running = 1'b0;
        logic         d = 1'b0;
        int           cnt = 0;
        logic [255:0] dg = '0;
        always @(posedge clk) begin
            if (!core_rst_n[gi]) begin
                running <= 1'b0;
                d       <= 1'b0;
                dg      <= '0;
                cnt     <= 0;
            end else if (core_start[gi]) begin
                running <= 1'b1;
                cnt     <= 2 + gi;
            end else if (running && !stuck_mask[gi]) begin
                if (cnt == 0) begin
                    running <= 1'b0;
                    d       <= 1'b1;
                    dg      <= model_digest(core_message[128*gi +: 32]);
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
        assign core_done[gi]            = d;
        assign core_outs[256*gi +: 256] = dg;
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && |core_start) begin
            start_log.push_back(core_start);
            msg_log.push_back(core_message);
            $display("launch: core_start=%b lane0 nonce=%h", core_start, core_message[31:0]);
        end
    end

    task automatic run_scan(input logic [31:0] base, input logic [31:0] cnt,
                            input logic [255:0] tgt, output int cycles);
        start_log.delete();
        msg_log.delete();
        @(negedge clk);
        nonce_base  = base;
        nonce_count = cnt;
        target      = tgt;
        start       = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        $display("scan base=%h count=%0d: done=%b after %0d cycles found=%b nonce=%h hashes=%0d",
                 base, cnt, done, cycles, found, found_nonce, hashes_done);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        start       = 1'b0;
        midstate    = SHA256_IV;
        hdr_tail    = TAIL;
        nonce_base  = 32'h1234_5678;
        nonce_count = 32'd9;
        target      = '1;
        repeat (3) @(negedge clk);
        n_vec++; if (core_rst_n !== 4'b0000) begin n_err++; $display("FAIL reset_core_rst_n: got %b want 0000", core_rst_n); end
        n_vec++; if (core_start !== 4'b0000) begin n_err++; $display("FAIL reset_core_start: got %b want 0000", core_start); end
        n_vec++; if ({busy, done, found, error} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, done, found, error}); end
        n_vec++; if (found_nonce !== 32'h0 || hashes_done !== 32'h0) begin n_err++; $display("FAIL reset_counters: got %h/%h want 0/0", found_nonce, hashes_done); end
        n_vec++; if (core_message !== '0 || core_inh !== '0 || found_digest !== '0) begin n_err++; $display("FAIL reset_data: got nonzero message/inh/digest, want all zero"); end
        reset_n = 1'b1;
        @(negedge clk);
        $display("reset test complete");
    endtask

    task automatic test_zero_count();
        int cyc;
        run_scan(32'h0000_0100, 32'd0, '1, cyc);
        n_vec++; if (done !== 1'b1 || cyc > 2) begin n_err++; $display("FAIL zero_done: got done=%b after %0d cycles want 1 within 2", done, cyc); end
        n_vec++; if (found !== 1'b0 || hashes_done !== 32'd0) begin n_err++; $display("FAIL zero_result: got found=%b hashes=%0d want 0/0", found, hashes_done); end
        n_vec++; if (start_log.size() !== 0) begin n_err++; $display("FAIL zero_no_launch: got %0d launches want 0", start_log.size()); end
        @(negedge clk);
    endtask

    task automatic test_single_batch();
        int cyc;
        run_scan(32'h0000_0100, 32'd10, '1, cyc);
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL single_done: got done=%b busy=%b want 1/0", done, busy); end
        n_vec++; if (found !== 1'b1 || found_nonce !== 32'h0000_0100) begin n_err++; $display("FAIL single_nonce: got found=%b nonce=%h want 1/00000100", found, found_nonce); end
        n_vec++; if (hashes_done !== 32'd4) begin n_err++; $display("FAIL single_hashes: got %0d want 4", hashes_done); end
        n_vec++; if (found_digest !== {32'hFFFF_FFFF, 192'h0, 32'h0000_0100}) begin n_err++; $display("FAIL single_digest: got %h", found_digest); end
        n_vec++; if (start_log.size() !== 1 || start_log[0] !== 4'b1111) begin n_err++; $display("FAIL single_launch: got %0d launches want 1 of 1111", start_log.size()); end
        n_vec++; if (msg_log.size() == 0 || msg_log[0][127:0] !== {TAIL, 32'h0000_0100} || msg_log[0][511:384] !== {TAIL, 32'h0000_0103}) begin n_err++; $display("FAIL single_message: lane messages wrong"); end
        n_vec++; if (core_inh !== SHA256_IV) begin n_err++; $display("FAIL single_inh: got %h want %h", core_inh, SHA256_IV); end
        @(negedge clk);
    endtask

    task automatic test_two_batches();
        int cyc;
        run_scan(32'h0000_0100, 32'd6, '0, cyc);
        n_vec++; if (done !== 1'b1 || found !== 1'b0 || hashes_done !== 32'd6) begin n_err++; $display("FAIL two_result: got done=%b found=%b hashes=%0d want 1/0/6", done, found, hashes_done); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL two_error: got %b want 0", error); end
        n_vec++; if (start_log.size() !== 2) begin n_err++; $display("FAIL two_launches: got %0d want 2", start_log.size()); end
        if (start_log.size() == 2) begin
            n_vec++; if (start_log[1] !== 4'b0011) begin n_err++; $display("FAIL two_mask: got %b want 0011", start_log[1]); end
            n_vec++; if (msg_log[1][31:0] !== 32'h104 || msg_log[1][159:128] !== 32'h105) begin n_err++; $display("FAIL two_nonces: got %h/%h want 00000104/00000105", msg_log[1][31:0], msg_log[1][159:128]); end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int cyc;
        hit_a = 32'h0; hit_a_en = 1'b1;
        run_scan(32'hFFFF_FFFE, 32'd4, TGT_HI0, cyc);
        n_vec++; if (found !== 1'b1 || found_nonce !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_nonce: got found=%b nonce=%h want 1/00000000", found, found_nonce); end
        n_vec++; if (found_digest !== 256'h0 || hashes_done !== 32'd4) begin n_err++; $display("FAIL wrap_digest: got digest=%h hashes=%0d want 0/4", found_digest, hashes_done); end
        if (msg_log.size() != 0) begin
            n_vec++;
            if ({msg_log[0][31:0], msg_log[0][159:128], msg_log[0][287:256], msg_log[0][415:384]} !==
                {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001}) begin
                n_err++; $display("FAIL wrap_lanes: got %h %h %h %h", msg_log[0][31:0], msg_log[0][159:128], msg_log[0][287:256], msg_log[0][415:384]);
            end
        end else begin
            n_vec++; n_err++; $display("FAIL wrap_launch: got 0 launches want 1");
        end
        hit_a_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multi_hit_busy_start();
        int cyc;
        hit_a = 32'h2001; hit_a_en = 1'b1;
        hit_b = 32'h2003; hit_b_en = 1'b1;
        start_log.delete();
        msg_log.delete();
        @(negedge clk);
        nonce_base = 32'h2000; nonce_count = 32'd8; target = TGT_HI0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL multi_busy: got %b want 1", busy); end
        nonce_base = 32'h9999; start = 1'b1;
        @(negedge clk);
        start = 1'b0; nonce_base = 32'h2000;
        cyc = 0;
        while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
        $display("multi-hit scan: done=%b found=%b nonce=%h hashes=%0d", done, found, found_nonce, hashes_done);
        n_vec++; if (found !== 1'b1 || found_nonce !== 32'h2001) begin n_err++; $display("FAIL multi_nonce: got found=%b nonce=%h want 1/00002001", found, found_nonce); end
        n_vec++; if (found_digest !== {32'h0, 192'h0, 32'h2001} || hashes_done !== 32'd4) begin n_err++; $display("FAIL multi_digest: got %h hashes=%0d", found_digest, hashes_done); end
        repeat (4) @(negedge clk);
        n_vec++; if (start_log.size() !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL busy_start_ignored: got %0d launches busy=%b want 1/0", start_log.size(), busy); end
        hit_a_en = 1'b0; hit_b_en = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        start_log.delete();
        msg_log.delete();
        @(negedge clk);
        nonce_base = 32'h3000; nonce_count = 32'd8; target = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (start_log.size() == 0 && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        n_vec++; if (busy !== 1'b1 || core_rst_n !== 4'b1111) begin n_err++; $display("FAIL midwait_pre: got busy=%b rst_n=%b want 1/1111", busy, core_rst_n); end
        reset_n = 1'b0;
        #1;
        $display("reset mid-WAIT: busy=%b core_rst_n=%b found=%b", busy, core_rst_n, found);
        n_vec++; if (busy !== 1'b0 || core_rst_n !== 4'b0000 || core_start !== 4'b0000) begin n_err++; $display("FAIL midwait_ctrl: got busy=%b rst_n=%b start=%b want 0/0000/0000", busy, core_rst_n, core_start); end
        n_vec++; if (found !== 1'b0 || found_nonce !== 32'h0 || found_digest !== '0) begin n_err++; $display("FAIL midwait_found: got found=%b nonce=%h want 0/0", found, found_nonce); end
        n_vec++; if (core_message !== '0 || core_inh !== '0 || hashes_done !== 32'h0 || done !== 1'b0) begin n_err++; $display("FAIL midwait_data: outputs not at reset values"); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0 || core_rst_n !== 4'b0000) begin n_err++; $display("FAIL midwait_idle: got busy=%b rst_n=%b want 0/0000", busy, core_rst_n); end
    endtask

`ifdef NONCE_DISPATCH_WATCHDOG_EN
    task automatic test_watchdog();
        int cyc;
        stuck_mask = 4'b0100;
        start_log.delete();
        msg_log.delete();
        @(negedge clk);
        nonce_base = 32'h5000; nonce_count = 32'd4; target = '1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(|core_start) && cyc < 20) begin @(negedge clk); cyc++; end
        // From the LAUNCH negedge: WAIT is entered one edge later and FINISH 512 edges after that
        cyc = 0;
        while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
        $display("watchdog scan: done=%b after %0d cycles error=%b", done, cyc, error);
        n_vec++; if (done !== 1'b1 || cyc !== TMO + 1) begin n_err++; $display("FAIL wdt_timing: got done=%b at %0d want 1 at %0d", done, cyc, TMO + 1); end
        n_vec++; if (error !== 1'b1 || found !== 1'b0 || hashes_done !== 32'd0) begin n_err++; $display("FAIL wdt_result: got error=%b found=%b hashes=%0d want 1/0/0", error, found, hashes_done); end
        stuck_mask = '0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_zero_count();
        test_single_batch();
        test_two_batches();
        test_wrap();
        test_multi_hit_busy_start();
        test_reset_mid_wait();
`ifdef NONCE_DISPATCH_WATCHDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
